// File: rtl/systolic_new_array.sv
// -----------------------------------------------------------------------------
// systolic_new_array
//
// Output-stationary systolic matrix multiplier: C = A x B, where A is
// ARRAY_ROWS x INPUT_LENGTH and B is INPUT_LENGTH x ARRAY_COLUMNS. On a start
// pulse the operand vectors are captured, row i of A is fed into the left edge
// of the PE grid delayed by i cycles and column j of B into the top edge
// delayed by j cycles. Each PE(i,j) keeps its own accumulator (acc += a*b,
// modulo 2^DATA_WIDTH) while A operands move right and B operands move down.
// After the reduction has drained through the grid, one DONE cycle copies all
// accumulators into the output buffer.
//
// Ports
//   clk               clock, rising edge
//   srstn             synchronous active-high reset
//   alu_start_0/1/2   start pulses for mode 0/1/2 (priority 0 > 1 > 2)
//   K0/K1/K2          reduction length for mode 0/1/2 (clamped to INPUT_LENGTH)
//   w_scale           modes 1/2: double the B operands before multiplying
//   A_vec             A(i,k) at bit (i*INPUT_LENGTH+k)*DATA_WIDTH
//   B_vec             B(k,j) at bit (k*ARRAY_COLUMNS+j)*DATA_WIDTH
//   mul_outcome       C(i,j) at bit (i*ARRAY_COLUMNS+j)*DATA_WIDTH, held
//   out_array         live accumulators of the bottom PE row
//   mode0_active      high during RUN and DONE of a mode-0 run
//   debug_*           zero-latency views of internal registers
// -----------------------------------------------------------------------------
module systolic_new_array #(
   parameter int ARRAY_ROWS    = 10,
   parameter int ARRAY_COLUMNS = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int INPUT_LENGTH  = 10
) (
   input  logic                                            clk,
   input  logic                                            srstn,
   input  logic                                            alu_start_0,
   input  logic                                            alu_start_1,
   input  logic                                            alu_start_2,
   input  logic [11:0]                                     K0,
   input  logic [11:0]                                     K1,
   input  logic [11:0]                                     K2,
   input  logic                                            w_scale,
   input  logic [ARRAY_ROWS*INPUT_LENGTH*DATA_WIDTH-1:0]    A_vec,
   input  logic [INPUT_LENGTH*ARRAY_COLUMNS*DATA_WIDTH-1:0] B_vec,
   output logic [ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH-1:0]   mul_outcome,
   output logic [ARRAY_COLUMNS*DATA_WIDTH-1:0]              out_array,
   output logic                                            mode0_active,
   output logic [DATA_WIDTH-1:0]                           debug_a0,
   output logic [DATA_WIDTH-1:0]                           debug_b0,
   output logic [DATA_WIDTH-1:0]                           debug_pe0,
   output logic [ARRAY_ROWS*DATA_WIDTH-1:0]                debug_A_shift,
   output logic [ARRAY_COLUMNS*DATA_WIDTH-1:0]             debug_B_shift,
   output logic [ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH-1:0]   debug_mac,
   output logic [ARRAY_ROWS*ARRAY_COLUMNS*DATA_WIDTH-1:0]   debug_out_buffer
);

   localparam int R  = ARRAY_ROWS;
   localparam int C  = ARRAY_COLUMNS;
   localparam int DW = DATA_WIDTH;
   localparam int L  = INPUT_LENGTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] MODE_0 = 2'd0;
   localparam logic [1:0] MODE_1 = 2'd1;
   localparam logic [1:0] MODE_2 = 2'd2;

   // Control state
   logic [1:0]    state_r;
   logic [11:0]   keff_r;
   logic [11:0]   cnt_r;
   logic          scale_r;
   logic          mode0_active_r;

   // Captured operands, inter-PE operand registers, accumulators, output buffer
   logic [DW-1:0] a_cap_r  [R][L];
   logic [DW-1:0] b_cap_r  [L][C];
   logic [DW-1:0] a_pipe_r [R][C];
   logic [DW-1:0] b_pipe_r [R][C];
   logic [DW-1:0] acc_r    [R][C];
   logic [DW-1:0] buf_r    [R][C];

   // Combinational helpers
   logic          start_any_s;
   logic [1:0]    sel_mode_s;
   logic [11:0]   sel_k_s;
   logic [11:0]   keff_next_s;
   logic [11:0]   run_len_s;
   logic          run_last_s;
   logic [DW-1:0] a_edge_s [R];
   logic [DW-1:0] b_edge_s [C];
   logic [DW-1:0] a_op_s   [R][C];
   logic [DW-1:0] b_op_s   [R][C];

   assign start_any_s = alu_start_0 | alu_start_1 | alu_start_2;

   // Start arbitration: mode 0 wins over 1, 1 wins over 2
   always_comb begin
      sel_mode_s = MODE_2;
      sel_k_s    = K2;
      if (alu_start_0) begin
         sel_mode_s = MODE_0;
         sel_k_s    = K0;
      end else if (alu_start_1) begin
         sel_mode_s = MODE_1;
         sel_k_s    = K1;
      end else begin
         sel_mode_s = MODE_2;
         sel_k_s    = K2;
      end
   end

   assign keff_next_s = (sel_k_s > 12'(L)) ? 12'(L) : sel_k_s;

   // RUN covers the skew of both edges plus the reduction itself; the compare
   // is written as >= so a zero-length run still leaves RUN after one cycle.
   assign run_len_s  = keff_r + 12'(R + C - 2);
   assign run_last_s = ((cnt_r + 12'd1) >= run_len_s);

   // Left-edge injection: row i sees A(i,k) at count i+k, zero outside window
   always_comb begin
      for (int i = 0; i < R; i++) begin
         a_edge_s[i] = {DW{1'b0}};
         for (int k = 0; k < L; k++) begin
            a_edge_s[i] = a_edge_s[i] |
               (((state_r == ST_RUN) && (cnt_r == 12'(i + k)) && (12'(k) < keff_r))
                  ? a_cap_r[i][k] : {DW{1'b0}});
         end
      end
   end

   // Top-edge injection: column j sees (optionally doubled) B(k,j) at count j+k
   always_comb begin
      for (int j = 0; j < C; j++) begin
         b_edge_s[j] = {DW{1'b0}};
         for (int k = 0; k < L; k++) begin
            b_edge_s[j] = b_edge_s[j] |
               (((state_r == ST_RUN) && (cnt_r == 12'(j + k)) && (12'(k) < keff_r))
                  ? (scale_r ? (b_cap_r[k][j] << 1) : b_cap_r[k][j]) : {DW{1'b0}});
         end
      end
   end

   // Operand seen by each PE: edge value on the boundary, neighbour register inside
   for (genvar gi = 0; gi < R; gi++) begin : g_op_row
      for (genvar gj = 0; gj < C; gj++) begin : g_op_col
         if (gj == 0) begin : g_a_edge
            assign a_op_s[gi][gj] = a_edge_s[gi];
         end else begin : g_a_pipe
            assign a_op_s[gi][gj] = a_pipe_r[gi][gj-1];
         end
         if (gi == 0) begin : g_b_edge
            assign b_op_s[gi][gj] = b_edge_s[gj];
         end else begin : g_b_pipe
            assign b_op_s[gi][gj] = b_pipe_r[gi-1][gj];
         end
      end
   end

   // Control FSM: run selection, length capture, cycle counter, mode-0 flag
   always_ff @(posedge clk) begin
      if (srstn) begin
         state_r        <= ST_IDLE;
         keff_r         <= 12'd0;
         cnt_r          <= 12'd0;
         scale_r        <= 1'b0;
         mode0_active_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_any_s) begin
                  state_r        <= ST_RUN;
                  keff_r         <= keff_next_s;
                  cnt_r          <= 12'd0;
                  // Weight doubling only exists for modes 1 and 2
                  scale_r        <= w_scale && (sel_mode_s != MODE_0);
                  mode0_active_r <= (sel_mode_s == MODE_0);
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + 12'd1;
               if (run_last_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r        <= ST_IDLE;
               mode0_active_r <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               mode0_active_r <= 1'b0;
            end
         endcase
      end
   end

   // Operand capture when a run is accepted
   always_ff @(posedge clk) begin
      if (srstn) begin
         for (int i = 0; i < R; i++) begin
            for (int k = 0; k < L; k++) begin
               a_cap_r[i][k] <= {DW{1'b0}};
            end
         end
         for (int k = 0; k < L; k++) begin
            for (int j = 0; j < C; j++) begin
               b_cap_r[k][j] <= {DW{1'b0}};
            end
         end
      end else if ((state_r == ST_IDLE) && start_any_s) begin
         for (int i = 0; i < R; i++) begin
            for (int k = 0; k < L; k++) begin
               a_cap_r[i][k] <= A_vec[(i*L + k)*DW +: DW];
            end
         end
         for (int k = 0; k < L; k++) begin
            for (int j = 0; j < C; j++) begin
               b_cap_r[k][j] <= B_vec[(k*C + j)*DW +: DW];
            end
         end
      end
   end

   // PE grid: operand shifting and multiply-accumulate
   always_ff @(posedge clk) begin
      if (srstn || ((state_r == ST_IDLE) && start_any_s)) begin
         for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
               a_pipe_r[i][j] <= {DW{1'b0}};
               b_pipe_r[i][j] <= {DW{1'b0}};
               acc_r[i][j]    <= {DW{1'b0}};
            end
         end
      end else if (state_r == ST_RUN) begin
         for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
               a_pipe_r[i][j] <= a_op_s[i][j];
               b_pipe_r[i][j] <= b_op_s[i][j];
               acc_r[i][j]    <= acc_r[i][j] + a_op_s[i][j] * b_op_s[i][j];
            end
         end
      end
   end

   // Output buffer: updated only in DONE, held otherwise
   always_ff @(posedge clk) begin
      if (srstn) begin
         for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
               buf_r[i][j] <= {DW{1'b0}};
            end
         end
      end else if (state_r == ST_DONE) begin
         for (int i = 0; i < R; i++) begin
            for (int j = 0; j < C; j++) begin
               buf_r[i][j] <= acc_r[i][j];
            end
         end
      end
   end

   // Output packing
   for (genvar gi = 0; gi < R; gi++) begin : g_pack_row
      assign debug_A_shift[gi*DW +: DW] = a_edge_s[gi];
      for (genvar gj = 0; gj < C; gj++) begin : g_pack_col
         assign mul_outcome[(gi*C + gj)*DW +: DW]      = buf_r[gi][gj];
         assign debug_out_buffer[(gi*C + gj)*DW +: DW] = buf_r[gi][gj];
         assign debug_mac[(gi*C + gj)*DW +: DW]        = acc_r[gi][gj];
      end
   end

   for (genvar gj = 0; gj < C; gj++) begin : g_pack_col_edge
      assign debug_B_shift[gj*DW +: DW] = b_edge_s[gj];
      assign out_array[gj*DW +: DW]     = acc_r[R-1][gj];
   end

   assign mode0_active = mode0_active_r;
   assign debug_a0     = a_op_s[0][0];
   assign debug_b0     = b_op_s[0][0];
   assign debug_pe0    = acc_r[0][0];

endmodule

// File: tb/tb_systolic_new_array.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_new_array. Stimulus pushes the expected product and
// its due cycle into a scoreboard queue; an independent monitor compares
// mul_outcome / debug_out_buffer when the result is due and also checks that
// the previous result is still held one cycle earlier.
// -----------------------------------------------------------------------------
module tb_systolic_new_array;

   localparam int R  = 10;
   localparam int C  = 10;
   localparam int DW = 32;
   localparam int L  = 10;
   localparam int NB = R*C*DW;

   logic                clk;
   logic                srstn;
   logic                alu_start_0, alu_start_1, alu_start_2;
   logic [11:0]         K0, K1, K2;
   logic                w_scale;
   logic [R*L*DW-1:0]   A_vec;
   logic [L*C*DW-1:0]   B_vec;
   logic [NB-1:0]       mul_outcome;
   logic [C*DW-1:0]     out_array;
   logic                mode0_active;
   logic [DW-1:0]       debug_a0, debug_b0, debug_pe0;
   logic [R*DW-1:0]     debug_A_shift;
   logic [C*DW-1:0]     debug_B_shift;
   logic [NB-1:0]       debug_mac;
   logic [NB-1:0]       debug_out_buffer;

   systolic_new_array #(
      .ARRAY_ROWS(R), .ARRAY_COLUMNS(C), .DATA_WIDTH(DW), .INPUT_LENGTH(L)
   ) dut (
      .clk(clk), .srstn(srstn),
      .alu_start_0(alu_start_0), .alu_start_1(alu_start_1), .alu_start_2(alu_start_2),
      .K0(K0), .K1(K1), .K2(K2), .w_scale(w_scale),
      .A_vec(A_vec), .B_vec(B_vec),
      .mul_outcome(mul_outcome), .out_array(out_array), .mode0_active(mode0_active),
      .debug_a0(debug_a0), .debug_b0(debug_b0), .debug_pe0(debug_pe0),
      .debug_A_shift(debug_A_shift), .debug_B_shift(debug_B_shift),
      .debug_mac(debug_mac), .debug_out_buffer(debug_out_buffer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   typedef struct {
      int            due;
      logic [NB-1:0] exp;
      logic [NB-1:0] prev;
   } item_t;

   item_t         sb_q[$];
   logic [NB-1:0] last_res;

   logic [DW-1:0] ta  [R][L];
   logic [DW-1:0] tbm [L][C];

   task automatic chk_vec(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      int e;
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         e = 0;
         for (int x = NB/DW - 1; x >= 0; x--)
            if (act[x*DW +: DW] !== exp[x*DW +: DW]) e = x;
         $display("FAIL %s: element %0d got %h want %h", name, e, act[e*DW +: DW], exp[e*DW +: DW]);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   // Reference: plain matrix product over the first keff terms, mod 2^32
   function automatic logic [NB-1:0] model(input int keff, input bit scale);
      logic [NB-1:0] res;
      logic [DW-1:0] s, bv;
      res = '0;
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++) begin
            s = '0;
            for (int k = 0; k < keff; k++) begin
               bv = scale ? (tbm[k][j] << 1) : tbm[k][j];
               s  = s + ta[i][k] * bv;
            end
            res[(i*C + j)*DW +: DW] = s;
         end
      return res;
   endfunction

   task automatic pack_ops();
      for (int i = 0; i < R; i++)
         for (int k = 0; k < L; k++) A_vec[(i*L + k)*DW +: DW] = ta[i][k];
      for (int k = 0; k < L; k++)
         for (int j = 0; j < C; j++) B_vec[(k*C + j)*DW +: DW] = tbm[k][j];
   endtask

   task automatic fill(input int kind);
      for (int i = 0; i < R; i++)
         for (int k = 0; k < L; k++) ta[i][k] = (kind == 0) ? 32'd0 : (kind == 1) ? 32'd1 : $urandom;
      for (int k = 0; k < L; k++)
         for (int j = 0; j < C; j++) tbm[k][j] = (kind == 0) ? 32'd0 : (kind == 1) ? 32'd1 : $urandom;
   endtask

   // Monitor: compares when the scoreboard head is due
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         if (cyc == sb_q[0].due - 1) begin
            chk_vec("hold_prev", mul_outcome, sb_q[0].prev);
         end else if (cyc == sb_q[0].due) begin
            chk_vec("result", mul_outcome, sb_q[0].exp);
            chk_vec("out_buffer", debug_out_buffer, sb_q[0].exp);
            void'(sb_q.pop_front());
         end
      end
   end

   // One run: called on a negedge, returns on a negedge with the run finished
   task automatic run(input bit [2:0] st, input int k0, input int k1, input int k2,
                      input bit sc, input bit glitch);
      int    mode, kk, keff, m0;
      item_t it;
      mode = st[0] ? 0 : (st[1] ? 1 : 2);
      kk   = (mode == 0) ? k0 : ((mode == 1) ? k1 : k2);
      keff = (kk > L) ? L : kk;
      K0 = 12'(k0); K1 = 12'(k1); K2 = 12'(k2); w_scale = sc;
      pack_ops();
      it.exp  = model(keff, sc && (mode != 0));
      it.prev = last_res;
      it.due  = cyc + 1 + keff + R + C - 1;
      sb_q.push_back(it);
      last_res = it.exp;
      alu_start_0 = st[0]; alu_start_1 = st[1]; alu_start_2 = st[2];
      @(negedge clk);
      m0 = 0;
      for (int n = 0; n < 60; n++) begin
         if (mode0_active) m0++;
         if (glitch && n == 5) {alu_start_0, alu_start_1, alu_start_2} = 3'b111;
         else {alu_start_0, alu_start_1, alu_start_2} = 3'b000;
         @(negedge clk);
      end
      chk32("mode0_cycles", m0, (mode == 0) ? (keff + R + C - 1) : 0);
      chk32("sb_drained", sb_q.size(), 0);
   endtask

   initial begin
      srstn = 1'b1;
      {alu_start_0, alu_start_1, alu_start_2} = 3'b000;
      K0 = 12'd0; K1 = 12'd0; K2 = 12'd0; w_scale = 1'b0;
      A_vec = '0; B_vec = '0;
      last_res = '0;
      repeat (2) @(negedge clk);
      srstn = 1'b0;
      chk_vec("rst_outcome", mul_outcome, '0);
      chk_vec("rst_mac", debug_mac, '0);
      chk32("rst_mode0", 32'(mode0_active), 32'd0);
      chk32("rst_pe0", debug_pe0, 32'd0);

      // Directed 2x2 corner
      fill(0);
      ta[0][0] = 32'd1; ta[1][1] = 32'd1;
      tbm[0][0] = 32'd5; tbm[0][1] = 32'd6; tbm[1][0] = 32'd7; tbm[1][1] = 32'd8;
      run(3'b001, 10, 0, 0, 1'b0, 1'b0);
      chk32("c00", mul_outcome[(0*C+0)*DW +: DW], 32'd5);
      chk32("c01", mul_outcome[(0*C+1)*DW +: DW], 32'd6);
      chk32("c10", mul_outcome[(1*C+0)*DW +: DW], 32'd7);
      chk32("c11", mul_outcome[(1*C+1)*DW +: DW], 32'd8);
      chk32("c22", mul_outcome[(2*C+2)*DW +: DW], 32'd0);

      // Random full products; w_scale has no effect in mode 0
      fill(2); run(3'b001, 10, 0, 0, 1'b0, 1'b0);
      fill(2); run(3'b001, 10, 0, 0, 1'b1, 1'b0);

      // Mode 1 with doubling, short reduction
      fill(1); run(3'b010, 7, 3, 9, 1'b1, 1'b0);
      chk32("k1_c00", mul_outcome[31:0], 32'd6);
      chk32("k1_c99", mul_outcome[NB-1 -: DW], 32'd6);

      // Simultaneous mode 0/2 starts, extra start pulse mid-run
      fill(1); run(3'b101, 2, 0, 5, 1'b0, 1'b1);
      chk32("prio_c55", mul_outcome[(5*C+5)*DW +: DW], 32'd2);

      // Mode 2 random with doubling
      fill(2); run(3'b100, 0, 0, 7, 1'b1, 1'b0);

      // Reset in the middle of a run
      fill(2); pack_ops(); K0 = 12'd10; w_scale = 1'b0;
      alu_start_0 = 1'b1;
      @(negedge clk);
      alu_start_0 = 1'b0;
      repeat (8) @(negedge clk);
      srstn = 1'b1;
      @(negedge clk);
      srstn = 1'b0;
      chk_vec("midrst_outcome", mul_outcome, '0);
      chk_vec("midrst_mac", debug_mac, '0);
      chk_vec("midrst_out_array", out_array, '0);
      chk_vec("midrst_A_shift", debug_A_shift, '0);
      chk_vec("midrst_B_shift", debug_B_shift, '0);
      chk32("midrst_mode0", 32'(mode0_active), 32'd0);
      last_res = '0;
      repeat (40) @(negedge clk);
      chk_vec("midrst_idle", mul_outcome, '0);

      // Zero-length reduction on non-zero data
      fill(2); run(3'b001, 0, 0, 0, 1'b0, 1'b0);

      // Oversized K is clamped
      fill(2); run(3'b001, 4095, 0, 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
